// File: rtl/idct_block_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | idct_pkg                                                                   |
// | Mode codes, block sizes and sequencer state type shared with idct_top.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package idct_pkg;

  localparam logic [1:0] IDCT_MODE_IDLE = 2'b00;
  localparam logic [1:0] IDCT_MODE_4X4  = 2'b01;
  localparam logic [1:0] IDCT_MODE_8X8  = 2'b10;

  localparam int BLK4_N = 16;
  localparam int BLK8_N = 64;

  typedef enum logic [0:0] {
    SEQ_FILL  = 1'b0,
    SEQ_DRAIN = 1'b1
  } seq_state_t;

  function automatic logic [5:0] blk_last_idx(input logic mode);
    return mode ? 6'(BLK8_N - 1) : 6'(BLK4_N - 1);
  endfunction

  function automatic logic [1:0] mode_code(input logic mode);
    return mode ? IDCT_MODE_8X8 : IDCT_MODE_4X4;
  endfunction

endpackage
`default_nettype wire

// File: rtl/idct_block_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | idct_block_sequencer_if                                                    |
// | Upstream coefficient stream (valid/ready) feeding the block sequencer.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface idct_block_sequencer_if #(
  parameter int DW = 16
);
  logic          s_valid;
  logic          s_ready;
  logic          s_mode;
  logic [DW-1:0] s_coef;

  modport master (output s_valid, output s_mode, output s_coef, input  s_ready);
  modport slave  (input  s_valid, input  s_mode, input  s_coef, output s_ready);
endinterface
`default_nettype wire

// File: rtl/idct_block_sequencer_coef_buf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | coef_buf                                                                   |
// | 64 x DW simple dual-port RAM, sync write, registered read (zero when idle).|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module coef_buf #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [5:0]    wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [5:0]    rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] r_mem [64];
  logic [DW-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // Read register doubles as the idct_in output register, so it idles at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= rd_en ? r_mem[rd_addr] : '0;
    end
  end

  assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/idct_block_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | idct_block_sequencer                                                       |
// | Buffers a 4x4/8x8 coefficient block, replays it to idct_top, tags results. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module idct_block_sequencer
  import idct_pkg::*;
#(
  parameter int DW       = 16,
  parameter int IDCT_LAT = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  idct_block_sequencer_if.slave  up,
  input  logic                   flush,
  output logic [1:0]             idct4,
  output logic [DW-1:0]          idct_in,
  input  logic [DW-1:0]          idct_out,
  output logic                   m_valid,
  output logic [DW-1:0]          m_data,
  output logic                   m_first,
  output logic                   m_last,
  output logic                   busy
);

  seq_state_t r_state, w_state_nxt;
  logic [5:0] r_cnt, w_cnt_nxt;
  logic       r_mode, w_mode_nxt;
  logic [1:0] r_idct4;
  logic [5:0] w_last_idx;
  logic       w_wr_en;
  logic       w_rd_en;
  logic [5:0] w_rd_addr;
  logic       w_tag_vld, w_tag_first, w_tag_last;
  logic [2:0] r_tag [IDCT_LAT];
  logic       w_inflight;

  assign up.s_ready = (r_state == SEQ_FILL);
  assign w_wr_en    = (r_state == SEQ_FILL) && up.s_valid && !flush;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_mode_nxt  = r_mode;
    w_rd_en     = 1'b0;
    w_rd_addr   = r_cnt + 6'd1;
    w_tag_vld   = 1'b0;
    w_tag_first = 1'b0;
    w_tag_last  = 1'b0;
    // On the first transfer the block size comes from the live s_mode.
    w_last_idx  = blk_last_idx(((r_state == SEQ_FILL) && (r_cnt == 6'd0)) ? up.s_mode : r_mode);
    unique case (r_state)
      SEQ_FILL: begin
        if (flush) begin
          w_cnt_nxt = 6'd0;
        end else if (up.s_valid) begin
          if (r_cnt == 6'd0) begin
            w_mode_nxt = up.s_mode;
          end
          if (r_cnt == w_last_idx) begin
            w_state_nxt = SEQ_DRAIN;
            w_cnt_nxt   = 6'd0;
            w_rd_en     = 1'b1;
            w_rd_addr   = 6'd0;
          end else begin
            w_cnt_nxt = r_cnt + 6'd1;
          end
        end
      end
      SEQ_DRAIN: begin
        // r_cnt is the index of the beat currently on idct_in.
        w_tag_vld   = 1'b1;
        w_tag_first = (r_cnt == 6'd0);
        w_tag_last  = (r_cnt == w_last_idx);
        if (r_cnt == w_last_idx) begin
          w_state_nxt = SEQ_FILL;
          w_cnt_nxt   = 6'd0;
        end else begin
          w_cnt_nxt = r_cnt + 6'd1;
          w_rd_en   = 1'b1;
        end
      end
      default: begin
        w_state_nxt = SEQ_FILL;
        w_cnt_nxt   = 6'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SEQ_FILL;
      r_cnt   <= 6'd0;
      r_mode  <= 1'b0;
      r_idct4 <= IDCT_MODE_IDLE;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_mode  <= w_mode_nxt;
      r_idct4 <= w_rd_en ? mode_code(w_mode_nxt) : IDCT_MODE_IDLE;
    end
  end

  // Tag delay line matching idct_top latency; stage 0 captures the current beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < IDCT_LAT; i++) begin
        r_tag[i] <= 3'b000;
      end
    end else begin
      r_tag[0] <= {w_tag_vld, w_tag_first, w_tag_last};
      for (int i = 1; i < IDCT_LAT; i++) begin
        r_tag[i] <= r_tag[i-1];
      end
    end
  end

  always_comb begin
    w_inflight = 1'b0;
    for (int i = 0; i < IDCT_LAT; i++) begin
      w_inflight = w_inflight | r_tag[i][2];
    end
  end

  coef_buf #(
    .DW (DW)
  ) u_coef_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (w_wr_en),
    .wr_addr (r_cnt),
    .wr_data (up.s_coef),
    .rd_en   (w_rd_en),
    .rd_addr (w_rd_addr),
    .rd_data (idct_in)
  );

  assign idct4   = r_idct4;
  assign m_valid = r_tag[IDCT_LAT-1][2];
  assign m_first = r_tag[IDCT_LAT-1][1];
  assign m_last  = r_tag[IDCT_LAT-1][0];
  assign m_data  = idct_out;
  assign busy    = (r_state == SEQ_DRAIN) | w_inflight;

endmodule
`default_nettype wire

// File: tb/tb_idct_block_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_idct_block_sequencer                                                    |
// | Random-stimulus bench with a cycle-indexed expectation model.              |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_idct_block_sequencer;
  import idct_pkg::*;

  localparam int DW  = 16;
  localparam int LAT = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic [1:0]    idct4;
  logic [DW-1:0] idct_in;
  logic [DW-1:0] idct_out = '0;
  logic [DW-1:0] m_data;
  logic          m_valid, m_first, m_last, busy;

  idct_block_sequencer_if #(.DW(DW)) up_if ();

  idct_block_sequencer #(.DW(DW), .IDCT_LAT(LAT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .up       (up_if),
    .flush    (flush),
    .idct4    (idct4),
    .idct_in  (idct_in),
    .idct_out (idct_out),
    .m_valid  (m_valid),
    .m_data   (m_data),
    .m_first  (m_first),
    .m_last   (m_last),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int nvalid = 0;

  // Expected outputs keyed by absolute cycle number.
  int exp_in   [int];
  int exp_code [int];
  int exp_v    [int];
  int exp_f    [int];
  int exp_l    [int];
  int blk      [$];
  bit blk_mode;
  int drain_start = 0;
  int drain_end   = 0;
  bit last_acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic bit draining(input int c);
    return (c >= drain_start) && (c < drain_end);
  endfunction

  function automatic int lk(input int c, input int sel);
    case (sel)
      0: return exp_in.exists(c)   ? exp_in[c]   : 0;
      1: return exp_code.exists(c) ? exp_code[c] : 0;
      2: return exp_v.exists(c)    ? exp_v[c]    : 0;
      3: return exp_f.exists(c)    ? exp_f[c]    : 0;
      default: return exp_l.exists(c) ? exp_l[c] : 0;
    endcase
  endfunction

  function automatic bit exp_busy(input int c);
    bit b = draining(c);
    for (int i = 0; i < LAT; i++) begin
      if (lk(c + i, 2) != 0) b = 1'b1;
    end
    return b;
  endfunction

  task automatic model_clear();
    exp_in.delete(); exp_code.delete(); exp_v.delete(); exp_f.delete(); exp_l.delete();
    blk.delete();
    drain_start = 0;
    drain_end   = 0;
  endtask

  task automatic model_update();
    int n;
    last_acc = 1'b0;
    if (!rst_n) begin
      model_clear();
      return;
    end
    if (draining(cyc)) return;
    if (flush) begin
      blk.delete();
    end else if (up_if.s_valid) begin
      last_acc = 1'b1;
      if (blk.size() == 0) blk_mode = up_if.s_mode;
      blk.push_back(32'(up_if.s_coef));
      n = blk_mode ? 64 : 16;
      if (blk.size() == n) begin
        for (int k = 0; k < n; k++) begin
          exp_in[cyc + 1 + k]         = blk[k];
          exp_code[cyc + 1 + k]       = blk_mode ? 2 : 1;
          exp_v[cyc + 1 + k + LAT]    = 1;
          exp_f[cyc + 1 + k + LAT]    = (k == 0) ? 1 : 0;
          exp_l[cyc + 1 + k + LAT]    = (k == n - 1) ? 1 : 0;
        end
        drain_start = cyc + 1;
        drain_end   = cyc + 1 + n;
        blk.delete();
      end
    end
  endtask

  task automatic check_cycle();
    bit dr = draining(cyc);
    chk("s_ready", 32'(up_if.s_ready), 32'(!dr));
    chk("idct4",   32'(idct4),   32'(lk(cyc, 1)));
    if (dr) chk("idct_in", 32'(idct_in), 32'(lk(cyc, 0)));
    chk("m_valid", 32'(m_valid), 32'(lk(cyc, 2)));
    chk("m_first", 32'(m_first), 32'(lk(cyc, 3)));
    chk("m_last",  32'(m_last),  32'(lk(cyc, 4)));
    chk("busy",    32'(busy),    32'(exp_busy(cyc)));
    chk("m_data",  32'(m_data),  32'(idct_out));
    if (m_valid) nvalid++;
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
    model_update();
    @(posedge clk);
    #1;
    cyc++;
    idct_out = 16'($urandom);
  endtask

  task automatic idle(input int n);
    up_if.s_valid = 1'b0;
    flush = 1'b0;
    repeat (n) step();
  endtask

  // gap: 0 = always valid, 1 = toggle, 2 = random
  task automatic send_coefs(input int n, input bit mode0, input int flip_at, input int gap, input bit seq);
    int k = 0;
    int guard = 0;
    while (k < n) begin
      up_if.s_valid = (gap == 0) ? 1'b1 : (gap == 1) ? ((guard % 2) == 0) : 1'($urandom_range(0, 1));
      up_if.s_mode  = (flip_at >= 0 && k >= flip_at) ? ~mode0 : mode0;
      up_if.s_coef  = seq ? 16'(k + 1) : 16'($urandom);
      step();
      if (last_acc) k++;
      guard++;
      if (guard > 1000) begin
        chk("send_timeout", 32'(0), 32'(1));
        break;
      end
    end
    up_if.s_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    up_if.s_valid = 1'b0;
    up_if.s_mode  = 1'b0;
    up_if.s_coef  = '0;
    @(posedge clk);
    #1;
    repeat (3) step();
    chk("rst_idct_in", 32'(idct_in), 32'(0));
    rst_n = 1'b1;
    idle(2);

    // 1: 4x4, coefs 1..16, no gaps
    send_coefs(16, 1'b0, -1, 0, 1'b1);
    idle(40);

    // 2: 8x8 with toggling valid
    send_coefs(64, 1'b1, -1, 1, 1'b0);
    idle(90);

    // 3: 8x8 then 4x4 back-to-back
    nvalid = 0;
    send_coefs(64, 1'b1, -1, 0, 1'b0);
    send_coefs(16, 1'b0, -1, 0, 1'b0);
    idle(120);
    chk("b2b_beats", 32'(nvalid), 32'(80));

    // 4: mode flips mid-block; flush during drain is ignored
    send_coefs(16, 1'b0, 3, 0, 1'b1);
    flush = 1'b1;
    repeat (3) step();
    idle(40);

    // 5: partial block, flush with coincident valid, then fresh block
    send_coefs(10, 1'b0, -1, 0, 1'b0);
    flush = 1'b1;
    up_if.s_valid = 1'b1;
    up_if.s_coef  = 16'hDEAD;
    step();
    flush = 1'b0;
    send_coefs(16, 1'b0, -1, 0, 1'b1);
    idle(40);

    // random blocks with random gaps
    for (int b = 0; b < 4; b++) begin
      send_coefs(($urandom_range(0, 1) != 0) ? 64 : 16, 1'b0, -1, 2, 1'b0);
      idle(5);
    end
    idle(100);

    // 6: reset mid-DRAIN of 8x8
    send_coefs(64, 1'b1, -1, 0, 1'b0);
    repeat (20) step();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_idct4",   32'(idct4),   32'(0));
    chk("rst_mid_m_valid", 32'(m_valid), 32'(0));
    chk("rst_mid_busy",    32'(busy),    32'(0));
    model_clear();
    repeat (3) step();
    rst_n = 1'b1;
    idle(80);
    send_coefs(16, 1'b0, -1, 0, 1'b0);
    idle(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
